// File: rtl/register_file.sv
// Integer register file for the Draig i32 core: two combinational read ports,
// one valid/ready write port, register 0 reads as zero, full clear on reset.
module register_file #(
  parameter int unsigned LOG_NUM_REG = 5,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] porta_rd_addr_in,
  output logic [DATA_WIDTH-1:0] porta_rd_data_out,
  input  logic [ADDR_WIDTH-1:0] portb_rd_addr_in,
  output logic [DATA_WIDTH-1:0] portb_rd_data_out,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  wr_data_valid_in,
  output logic                  wr_data_ready_out
);

  localparam int unsigned NumReg = 2 ** LOG_NUM_REG;
  // One extra bit so the bound is representable when ADDR_WIDTH == LOG_NUM_REG.
  localparam logic [ADDR_WIDTH:0] NumRegExt = (ADDR_WIDTH + 1)'(NumReg);

  logic [DATA_WIDTH-1:0]  mem_q [NumReg];
  logic                   ready_q;

  logic [LOG_NUM_REG-1:0] porta_idx;
  logic [LOG_NUM_REG-1:0] portb_idx;
  logic [LOG_NUM_REG-1:0] wr_idx;
  logic                   porta_hit;
  logic                   portb_hit;
  logic                   wr_hit;
  logic                   wr_fire;

  // Decode addresses: a hit is a nonzero address inside the implemented range.
  always_comb begin
    porta_idx = porta_rd_addr_in[LOG_NUM_REG-1:0];
    portb_idx = portb_rd_addr_in[LOG_NUM_REG-1:0];
    wr_idx    = wr_addr_in[LOG_NUM_REG-1:0];
    porta_hit = (porta_rd_addr_in != '0) && ({1'b0, porta_rd_addr_in} < NumRegExt);
    portb_hit = (portb_rd_addr_in != '0) && ({1'b0, portb_rd_addr_in} < NumRegExt);
    wr_hit    = (wr_addr_in != '0) && ({1'b0, wr_addr_in} < NumRegExt);
    wr_fire   = wr_data_valid_in && ready_q;
  end

  // Combinational read ports; no bypass, so a same-cycle write shows next cycle.
  always_comb begin
    porta_rd_data_out = '0;
    portb_rd_data_out = '0;
    if (porta_hit) porta_rd_data_out = mem_q[porta_idx];
    if (portb_hit) portb_rd_data_out = mem_q[portb_idx];
  end

  // Storage: cleared asynchronously; fired writes to 0 or out of range are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumReg; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire && wr_hit) begin
      mem_q[wr_idx] <= wr_data_in;
    end
  end

  // Ready is low in reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign wr_data_ready_out = ready_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random traffic
// checked against an array-based reference model. Six address bits are used so
// out-of-range addresses (32..63) can be exercised.
module tb_register_file;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] porta_rd_addr_in;
  logic [DW-1:0] porta_rd_data_out;
  logic [AW-1:0] portb_rd_addr_in;
  logic [DW-1:0] portb_rd_data_out;
  logic [AW-1:0] wr_addr_in;
  logic [DW-1:0] wr_data_in;
  logic          wr_data_valid_in;
  logic          wr_data_ready_out;

  int total;
  int bad;

  // Reference model
  logic [DW-1:0] model [32];
  logic          model_ready;

  register_file #(
    .LOG_NUM_REG(5),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .porta_rd_addr_in (porta_rd_addr_in),
    .porta_rd_data_out(porta_rd_data_out),
    .portb_rd_addr_in (portb_rd_addr_in),
    .portb_rd_data_out(portb_rd_data_out),
    .wr_addr_in       (wr_addr_in),
    .wr_data_in       (wr_data_in),
    .wr_data_valid_in (wr_data_valid_in),
    .wr_data_ready_out(wr_data_ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (a == 0 || a >= 32) return '0;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
    model_ready = 1'b0;
  endtask

  // Advance one clock; model applies a fired write, then sample point is edge+1.
  task automatic step();
    logic          fire;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    fire = wr_data_valid_in && model_ready && rst;
    a    = wr_addr_in;
    d    = wr_data_in;
    @(posedge clk);
    if (rst) begin
      if (fire && a != 0 && a < 32) model[a] = d;
      model_ready = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_data_valid_in = 1'b0;
    wr_addr_in = '0;
    wr_data_in = '0;
    porta_rd_addr_in = '0;
    portb_rd_addr_in = '0;
    model_clear();
    #2 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      porta_rd_addr_in = AW'(i);
      portb_rd_addr_in = AW'((15 + i) % 32);
      #1;
      total++;
      if (porta_rd_data_out !== 32'h0 || portb_rd_data_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_read a=%0d b=%0d got %h/%h want 0", i, (15 + i) % 32,
                 porta_rd_data_out, portb_rd_data_out);
      end
      total++;
      if (wr_data_ready_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_ready got %b want 0", wr_data_ready_out);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (wr_data_ready_out !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge got %b want 0", wr_data_ready_out);
    end
    step();
    total++;
    if (wr_data_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_edge got %b want 1", wr_data_ready_out);
    end
  endtask

  task automatic test_basic();
    wr_addr_in = 6'd5;
    wr_data_in = 32'hDEADBEEF;
    wr_data_valid_in = 1'b1;
    step();
    wr_addr_in = 6'd31;
    wr_data_in = 32'h12345678;
    porta_rd_addr_in = 6'd5;
    #1;
    total++;
    if (porta_rd_data_out !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_a5 got %h want deadbeef", porta_rd_data_out);
    end
    step();
    wr_data_valid_in = 1'b0;
    portb_rd_addr_in = 6'd31;
    #1;
    total++;
    if (portb_rd_data_out !== 32'h12345678) begin
      bad++;
      $display("FAIL basic_b31 got %h want 12345678", portb_rd_data_out);
    end
  endtask

  task automatic test_reg0();
    wr_addr_in = 6'd0;
    wr_data_in = 32'hFFFFFFFF;
    wr_data_valid_in = 1'b1;
    #1;
    total++;
    if (wr_data_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL reg0_ready got %b want 1", wr_data_ready_out);
    end
    step();
    // Out-of-range write aliasing register 5 must be discarded.
    wr_addr_in = 6'd37;
    wr_data_in = 32'h0BADF00D;
    step();
    wr_data_valid_in = 1'b0;
    porta_rd_addr_in = 6'd0;
    portb_rd_addr_in = 6'd0;
    #1;
    total++;
    if (porta_rd_data_out !== 32'h0 || portb_rd_data_out !== 32'h0) begin
      bad++;
      $display("FAIL reg0_read got %h/%h want 0", porta_rd_data_out, portb_rd_data_out);
    end
    porta_rd_addr_in = 6'd5;
    portb_rd_addr_in = 6'd37;
    #1;
    total++;
    if (porta_rd_data_out !== 32'hDEADBEEF || portb_rd_data_out !== 32'h0) begin
      bad++;
      $display("FAIL out_of_range got %h/%h want deadbeef/0", porta_rd_data_out,
               portb_rd_data_out);
    end
  endtask

  task automatic test_collision();
    wr_addr_in = 6'd7;
    wr_data_in = 32'hA;
    wr_data_valid_in = 1'b1;
    step();
    wr_data_in = 32'hB;
    porta_rd_addr_in = 6'd7;
    portb_rd_addr_in = 6'd7;
    #1;
    total++;
    if (porta_rd_data_out !== 32'hA || portb_rd_data_out !== 32'hA) begin
      bad++;
      $display("FAIL collision_old got %h/%h want a", porta_rd_data_out, portb_rd_data_out);
    end
    step();
    wr_data_valid_in = 1'b0;
    #1;
    total++;
    if (porta_rd_data_out !== 32'hB || portb_rd_data_out !== 32'hB) begin
      bad++;
      $display("FAIL collision_new got %h/%h want b", porta_rd_data_out, portb_rd_data_out);
    end
  endtask

  task automatic test_sweep();
    wr_data_valid_in = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wr_addr_in = AW'(i);
      wr_data_in = 32'(i) * 32'h01010101;
      step();
    end
    wr_data_valid_in = 1'b0;
    for (int c = 0; c < 64; c++) begin
      porta_rd_addr_in = AW'(c % 32);
      portb_rd_addr_in = AW'((15 + c) % 32);
      #1;
      total++;
      if (porta_rd_data_out !== 32'(c % 32) * 32'h01010101 ||
          portb_rd_data_out !== 32'((15 + c) % 32) * 32'h01010101) begin
        bad++;
        $display("FAIL sweep c=%0d got %h/%h want %h/%h", c, porta_rd_data_out,
                 portb_rd_data_out, 32'(c % 32) * 32'h01010101,
                 32'((15 + c) % 32) * 32'h01010101);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b0;
    model_clear();
    #1;
    total++;
    if (wr_data_ready_out !== 1'b0) begin
      bad++;
      $display("FAIL async_ready got %b want 0", wr_data_ready_out);
    end
    for (int i = 0; i < 32; i++) begin
      porta_rd_addr_in = AW'(i);
      portb_rd_addr_in = AW'(31 - i);
      #0.1;
      total++;
      if (porta_rd_data_out !== 32'h0 || portb_rd_data_out !== 32'h0) begin
        bad++;
        $display("FAIL async_read a=%0d got %h/%h want 0", i, porta_rd_data_out,
                 portb_rd_data_out);
      end
    end
    step();
    step();
    rst = 1'b1;
    step();
    wr_addr_in = 6'd9;
    wr_data_in = 32'hCAFEF00D;
    wr_data_valid_in = 1'b1;
    step();
    wr_data_valid_in = 1'b0;
    porta_rd_addr_in = 6'd9;
    #1;
    total++;
    if (porta_rd_data_out !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL post_reset_write got %h want cafef00d", porta_rd_data_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wr_data_valid_in = ($urandom_range(0, 3) != 0);
      wr_addr_in = AW'($urandom_range(0, 63));
      wr_data_in = $urandom;
      porta_rd_addr_in = AW'($urandom_range(0, 63));
      portb_rd_addr_in = ($urandom_range(0, 3) == 0) ? wr_addr_in : AW'($urandom_range(0, 63));
      #1;
      total++;
      if (porta_rd_data_out !== model_rd(porta_rd_addr_in) ||
          portb_rd_data_out !== model_rd(portb_rd_addr_in) ||
          wr_data_ready_out !== model_ready) begin
        bad++;
        $display("FAIL random c=%0d a=%0d b=%0d got %h/%h/%b want %h/%h/%b", c,
                 porta_rd_addr_in, portb_rd_addr_in, porta_rd_data_out, portb_rd_data_out,
                 wr_data_ready_out, model_rd(porta_rd_addr_in), model_rd(portb_rd_addr_in),
                 model_ready);
      end
      step();
    end
    wr_data_valid_in = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_reg0();
    test_collision();
    test_sweep();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Multi-ported integer register file for the Draig i32 processor core. Provides two independent combinational read ports (source operands A and B) and one write port with a valid/ready handshake fed by the writeback stage. Register 0 is hardwired to zero. All storage clears on reset.

## Interface

Parameters:
- LOG_NUM_REG, default 5: log2 of register count; 2^LOG_NUM_REG registers (32 by default).
- ADDR_WIDTH, default 5: width of all address ports; must be ≥ LOG_NUM_REG.
- DATA_WIDTH, default 32: register width in bits.

Ports:
- clk  in  1  clock. The block uses one clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- porta_rd_addr_in  in  ADDR_WIDTH  read port A address.
- porta_rd_data_out  out  DATA_WIDTH  read port A data.
- portb_rd_addr_in  in  ADDR_WIDTH  read port B address.
- portb_rd_data_out  out  DATA_WIDTH  read port B data.
- wr_addr_in  in  ADDR_WIDTH  write address.
- wr_data_in  in  DATA_WIDTH  write data.
- wr_data_valid_in  in  1  write request valid.
- wr_data_ready_out  out  1  block can accept a write.

## Operation

- Storage: 2^LOG_NUM_REG registers, each DATA_WIDTH bits, reg[0..N-1].
- Reads: each port is purely combinational. The output is reg[addr] when addr < 2^LOG_NUM_REG and addr ≠ 0. The output is 0 when addr = 0 or addr ≥ 2^LOG_NUM_REG.
- Ports A and B are fully independent and may address the same register.
- Write handshake: a write fires on a rising clk edge where wr_data_valid_in && wr_data_ready_out. On fire, reg[wr_addr_in] <= wr_data_in.
- A fired write to address 0 or to an address ≥ 2^LOG_NUM_REG is accepted (handshake completes) and discarded.
- wr_data_ready_out is registered. It is 0 while rst is asserted and 1 from the first rising edge after rst deasserts.
- The block never applies backpressure outside reset, so one write per cycle is sustainable.
- Valid without ready (during reset) does nothing. The requester holds its request until ready.
- No read-during-write bypass. A read of the register being written in the same cycle returns the old value. The new value appears on the read outputs immediately after the write edge.

## Timing

- Reset (rst=0): asynchronous. All registers clear to 0 immediately and wr_data_ready_out goes to 0. Read outputs therefore show 0 for every address while reset is held.
- Reset mid-operation: any write not yet fired is lost. Contents clear regardless of pending handshakes.
- Read latency: 0 cycles (combinational, address to data).
- Write latency: data is visible on the read ports in the cycle following the fire edge, i.e. 1 clock.
- Back-to-back writes to the same address: the last fired write wins. Each cycle updates independently.
- Reads never stall. There is no state machine beyond the ready flag, which is 0 in reset and 1 once running.

## Test plan

- Reset: hold rst=0 for 3 cycles then release. Sweep porta from 0 to 31 and portb from 15 upward with wrap. Required: all read data = 0, and wr_data_ready_out = 0 during reset and 1 from the first edge after release.
- Basic write/read: write 0xDEADBEEF to addr 5 and 0x12345678 to addr 31 in consecutive cycles. Required: the next cycle after each write, porta_addr=5 gives 0xDEADBEEF and portb_addr=31 gives 0x12345678.
- Register 0: write 0xFFFFFFFF to addr 0 with valid=1. Required: the handshake completes (ready=1), and both ports read 0 at addr 0 thereafter.
- Same-cycle collision: addr 7 holds 0xA; write 0xB to addr 7 while porta and portb both read 7. Required: both ports show 0xA that cycle and 0xB the next.
- Full sweep: write reg[i]=i*0x01010101 for i=1..31, then continuously increment porta from 0 and portb from 15 (both wrap at 31). Required: each port shows its address's value every cycle, with 0 at addr 0.
- Async reset mid-run: after the sweep, assert rst between clock edges. Required: all reads go to 0 and ready drops to 0 without waiting for a clock edge. After release, writes succeed again.
